posit_accum_ctrl: RTL and testbench
===================================

# posit_accum_ctrl

Sequential reduction controller that sums a stream of 32-bit, es=2 posits by driving an external pipelined posit adder instance (`positadd_8`). It acts as the initiator side of the adder's start/done interface. It accepts one packet of posits (ready/valid, last-flagged), keeps one addition in flight at a time, and emits the posit sum of the packet. It sits between a posit data source and the pipelined adder, and provides packet-level accumulation for dot-product style datapaths.

## Interface
- ADD_LATENCY, 8, cycles from the cycle `add_start` is high to the cycle `add_done` is high; also the post-reset flush length
- CNT_W, 16, width of `out_count`
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  32  posit operand
- in_valid  input  1  operand valid
- in_last  input  1  operand is the final element of its packet
- in_ready  output  1  controller accepts an operand this cycle
- out_data  output  32  packet sum (posit)
- out_inf  output  1  sum is NaR (0x80000000)
- out_count  output  CNT_W  number of elements in the packet, saturating at all-ones
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- add_in1, add_in2  output  32  adder operands
- add_start  output  1  one-cycle adder issue pulse
- add_result  input  32  adder result
- add_done  input  1  adder result valid
- add_inf, add_zero  input  1  adder flags

## Operation
- States: FLUSH, IDLE (accumulator empty), ACCUM (accumulator holds a value), ADD (waiting for the adder), OUT (result held).
- FLUSH: entered on reset. A down-counter loads ADD_LATENCY and decrements every cycle. At 0, the controller goes to IDLE. `add_done` is ignored in this state, because the adder has no reset and can deliver a stale pulse.
- `in_ready` = 1 only in IDLE and ACCUM. An operand is accepted when `in_valid & in_ready`.
- IDLE accept:
  - acc ← in_data, count ← 1, inf ← (in_data == 0x80000000).
  - If `in_last`, go to OUT; otherwise go to ACCUM. No add is issued.
- ACCUM accept:
  - Register `add_in1` = acc and `add_in2` = in_data. Pulse `add_start` for exactly one cycle.
  - Latch `in_last` as a pending_last flag. count ← count+1, saturating. Go to ADD.
  - `add_in1`/`add_in2` hold their values until `add_done`.
- ADD: wait for `add_done`.
  - On `add_done`: acc ← add_result, inf ← inf | add_inf.
  - If pending_last, go to OUT; otherwise go to ACCUM.
  - `add_done` seen in any state other than ADD is ignored.
- OUT: `out_valid` = 1. `out_data` = acc, `out_inf` = inf, `out_count` = count.
  - All three are held stable while `out_ready` = 0.
  - On `out_valid & out_ready`: go to IDLE and clear acc, inf and count.
- A zero result is passed through as 0x00000000. `add_zero` is informational only.
- Reset mid-operation (any state): all state is discarded immediately, the controller enters FLUSH, and the in-flight adder result is dropped.

## Timing
- Reset values:
  - `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `out_inf` = 0, `out_count` = 0.
  - `add_start` = 0, `add_in1` = 0, `add_in2` = 0. State = FLUSH.
- First `in_ready` = 1 occurs ADD_LATENCY cycles after the first rising edge following reset release.
- For an operand accepted in ACCUM in cycle n:
  - `add_start` = 1 in cycle n+1.
  - `add_done` is expected in cycle n+1+ADD_LATENCY; acc updates at the end of that cycle.
  - `in_ready` = 1 again in cycle n+2+ADD_LATENCY, or `out_valid` = 1 if that operand was last.
- Steady-state throughput: one operand per ADD_LATENCY+2 cycles.
- Single-element packet: accepted in cycle n, `out_valid` = 1 in cycle n+1.
- `out_valid` is registered and never asserts in the same cycle as `in_ready`.

## Test plan
- Reset, then hold reset low: all outputs are 0 and `in_ready` stays 0 for 8 cycles, then rises. A spurious `add_done` pulse during flush causes no state change.
- Packet {0x40000000, 0x40000000 last} (1+1):
  - `add_start` pulses once with add_in1 = add_in2 = 0x40000000.
  - Result: out_data = 0x48000000, out_count = 2, out_inf = 0.
  - `out_valid` rises 10 cycles after the second accept.
- Single packet {0xC0000000 last}: out_data = 0xC0000000 and out_count = 1 one cycle after accept. `add_start` never asserts.
- Packet {0x40000000, 0xC0000000, 0x80000000 last}: the intermediate sum is 0x00000000. The final result is out_data = 0x80000000, out_inf = 1, out_count = 3.
- Hold `out_ready` = 0 for 5 cycles with `out_valid` = 1:
  - `out_data`, `out_count` and `out_inf` stay stable and `in_ready` stays 0.
  - Raise `out_ready` for one cycle: `out_valid` drops and `in_ready` = 1 on the next cycle.
- Assert reset 3 cycles after an `add_start`:
  - Outputs return to reset values.
  - The stale `add_done` 5 cycles later is ignored.
  - A following packet {0x40000000 last} yields 0x40000000.

Source files
------------

// File: rtl/posit_accum_ctrl.sv
// Packet-level posit accumulator that drives an external pipelined posit adder.
// One addition is in flight at a time; the packet sum is held until the consumer takes it.
module posit_accum_ctrl #(
  parameter int ADD_LATENCY = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_inf,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      add_in1,
  output logic [31:0]      add_in2,
  output logic             add_start,
  input  logic [31:0]      add_result,
  input  logic             add_done,
  input  logic             add_inf,
  input  logic             add_zero
);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ACCUM,
    S_ADD,
    S_OUT
  } state_t;

  localparam logic [31:0]  NAR        = 32'h8000_0000;
  localparam int           FW         = (ADD_LATENCY < 1) ? 1 : $clog2(ADD_LATENCY + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(ADD_LATENCY);

  state_t           state_q, state_d;
  logic [FW-1:0]    flush_cnt;
  logic [31:0]      acc;
  logic             acc_inf;
  logic [CNT_W-1:0] count;
  logic             pending_last;
  logic             accept;

  // The zero flag carries no information the sum itself does not already carry.
  logic unused_add_zero;
  assign unused_add_zero = add_zero;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FLUSH;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FLUSH: if (flush_cnt == '0) state_d = S_IDLE;
      S_IDLE:  if (accept)          state_d = in_last ? S_OUT : S_ACCUM;
      S_ACCUM: if (accept)          state_d = S_ADD;
      S_ADD:   if (add_done)        state_d = pending_last ? S_OUT : S_ACCUM;
      S_OUT:   if (out_ready)       state_d = S_IDLE;
      default:                      state_d = S_FLUSH;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
    out_valid = (state_q == S_OUT);
    accept    = in_valid && in_ready;
  end

  assign out_data  = acc;
  assign out_inf   = acc_inf;
  assign out_count = count;

  // The adder has no reset, so the flush window outlasts any result it may still deliver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt    <= FLUSH_INIT;
      acc          <= '0;
      acc_inf      <= 1'b0;
      count        <= '0;
      pending_last <= 1'b0;
      add_in1      <= '0;
      add_in2      <= '0;
      add_start    <= 1'b0;
    end else begin
      add_start <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
        end
        S_IDLE: begin
          if (accept) begin
            acc     <= in_data;
            acc_inf <= (in_data == NAR);
            count   <= CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (accept) begin
            add_in1      <= acc;
            add_in2      <= in_data;
            add_start    <= 1'b1;
            pending_last <= in_last;
            if (count != '1) count <= count + 1'b1;
          end
        end
        S_ADD: begin
          if (add_done) begin
            acc     <= add_result;
            acc_inf <= acc_inf | add_inf;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc     <= '0;
            acc_inf <= 1'b0;
            count   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_accum_ctrl.sv
// Self-checking bench for posit_accum_ctrl with a behavioural 8-stage posit adder model.
module tb_posit_accum_ctrl;

  localparam int LAT = 8;
  localparam logic [31:0] NAR  = 32'h8000_0000;
  localparam logic [31:0] ONE  = 32'h4000_0000;
  localparam logic [31:0] MONE = 32'hC000_0000;
  localparam logic [31:0] TWO  = 32'h4800_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic        out_inf, out_valid, out_ready;
  logic [15:0] out_count;
  logic [31:0] add_in1, add_in2, add_result;
  logic        add_start, add_done, add_inf, add_zero;

  always #5 clk = ~clk;

  posit_accum_ctrl #(.ADD_LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_inf(out_inf), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_done(add_done), .add_inf(add_inf), .add_zero(add_zero)
  );

  // Posit sums for the operand pairs the vectors exercise.
  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    if (a == 32'h0) return b;
    if (b == 32'h0) return a;
    if (a == ONE && b == ONE) return TWO;
    if ((a == ONE && b == MONE) || (a == MONE && b == ONE)) return 32'h0;
    if ((a == TWO && b == MONE) || (a == MONE && b == TWO)) return ONE;
    return 32'hDEAD_BEEF;
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [31:0]    pr [LAT];
  logic           spurious = 1'b0;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], add_start};
    pr[0] <= model_sum(add_in1, add_in2);
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
  end

  assign add_done   = pv[LAT-1] | spurious;
  assign add_result = spurious ? 32'h1234_5678 : pr[LAT-1];
  assign add_inf    = pv[LAT-1] && (pr[LAT-1] == NAR);
  assign add_zero   = pv[LAT-1] && (pr[LAT-1] == 32'h0);

  int          n_starts = 0;
  int          overlap  = 0;
  logic [31:0] last_in1 = '0, last_in2 = '0;

  always @(negedge clk) begin
    if (add_start) begin
      n_starts++;
      last_in1 = add_in1;
      last_in2 = add_in2;
    end
    if (in_ready && out_valid) overlap++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int budget = 100;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && budget > 0) begin
      step();
      budget--;
    end
    check("accept_in_time", {31'b0, budget > 0}, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"},  out_data,           32'd0);
    check({tag, "_out_inf"},   {31'b0, out_inf},   32'd0);
    check({tag, "_out_count"}, {16'b0, out_count}, 32'd0);
    check({tag, "_add_start"}, {31'b0, add_start}, 32'd0);
    check({tag, "_add_in1"},   add_in1,            32'd0);
    check({tag, "_add_in2"},   add_in2,            32'd0);
  endtask

  typedef struct {
    int               n;
    logic [2:0][31:0] d;
    logic [31:0]      e_data;
    logic             e_inf;
    logic [15:0]      e_cnt;
    int               e_lat;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int starts_before;
    logic [31:0] held_data;

    tbl[0] = '{n: 2, d: {32'h0, ONE, ONE},   e_data: TWO,  e_inf: 1'b0, e_cnt: 16'd2, e_lat: 9};
    tbl[1] = '{n: 1, d: {32'h0, 32'h0, MONE}, e_data: MONE, e_inf: 1'b0, e_cnt: 16'd1, e_lat: 0};
    tbl[2] = '{n: 3, d: {NAR, MONE, ONE},    e_data: NAR,  e_inf: 1'b1, e_cnt: 16'd3, e_lat: 9};
    tbl[3] = '{n: 3, d: {MONE, ONE, ONE},    e_data: ONE,  e_inf: 1'b0, e_cnt: 16'd3, e_lat: 9};

    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_reset_outputs("rst");

    // Flush window: in_ready stays low for 8 cycles; a stray add_done lands in the middle.
    reset = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      if (k == 4) spurious = 1'b1;
      step();
      spurious = 1'b0;
      check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    end
    step();
    check("flush_done_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_out_valid",     {31'b0, out_valid}, 32'd0);
    check("flush_out_data",      out_data, 32'd0);

    for (int i = 0; i < 4; i++) begin
      starts_before = n_starts;
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].d[j], j == tbl[i].n - 1);
      wait_out(lat);
      check("result_latency", lat, tbl[i].e_lat);
      check("out_data",  out_data, tbl[i].e_data);
      check("out_inf",   {31'b0, out_inf}, {31'b0, tbl[i].e_inf});
      check("out_count", {16'b0, out_count}, {16'b0, tbl[i].e_cnt});
      check("add_starts", n_starts - starts_before, tbl[i].n - 1);
      if (i == 0) begin
        check("add_in1", last_in1, ONE);
        check("add_in2", last_in2, ONE);
        held_data = out_data;
        for (int k = 0; k < 5; k++) begin
          step();
          check("hold_valid", {31'b0, out_valid}, 32'd1);
          check("hold_data",  out_data, held_data);
          check("hold_count", {16'b0, out_count}, 32'd2);
          check("hold_inf",   {31'b0, out_inf}, 32'd0);
          check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("ack_out_valid", {31'b0, out_valid}, 32'd0);
      check("ack_in_ready",  {31'b0, in_ready},  32'd1);
    end

    // Reset three cycles after an add issue; the stale add_done arrives during flush.
    send(ONE, 1'b0);
    send(ONE, 1'b0);
    check("midrst_add_start", {31'b0, add_start}, 32'd1);
    repeat (3) step();
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    reset = 1'b0;
    send(ONE, 1'b1);
    wait_out(lat);
    check("post_rst_latency", lat, 0);
    check("post_rst_data",  out_data, ONE);
    check("post_rst_count", {16'b0, out_count}, 32'd1);
    check("post_rst_inf",   {31'b0, out_inf}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    check("ready_valid_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
